gpio_ctrl_v2: RTL and testbench
===============================

Name: gpio_ctrl_v2

Overview:
- Second-generation memory-mapped GPIO controller on the RISC-V microcontroller peripheral bus.
- Pin count and synchronizer depth are parametrised.
- Adds input synchronisation, per-pin edge-detect interrupts with write-1-to-clear pending bits, atomic set/clear of output data, and a registered interrupt line to the core.

Parameters:
- NUM_PINS, 16, number of GPIO pins (1..32); register bits above NUM_PINS-1 read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop stages on each pin input (2..4).
- DEBOUNCE_CYCLES, 16, stable-sample count required by the optional debounce filter (2..255).

Ports:
- clk  input  1  master clock
- reset_n  input  1  asynchronous active-low reset
- sel  input  1  bus access strobe; no access happens when low
- addr  input  4 ([5:2])  word address, 16 x 32-bit registers
- wben  input  4  write byte enables; bit n covers wdata[8n+7:8n]
- r_wn  input  1  1 = read, 0 = write (qualified by sel)
- wdata  input  32  write data
- ro_gpio_pinstate  input  NUM_PINS  raw asynchronous pin inputs
- rdata  output  32  registered read data
- rf_gpio_datareg  output  NUM_PINS  output data
- rf_gpio_tristate  output  NUM_PINS  output enables
- gpio_irq  output  1  registered interrupt request

Behaviour:
- Reset: asynchronous, active-low. All outputs, RW registers, pending bits, synchronizers, edge history and arm counter go to 0 immediately when reset_n goes low. Reset is released synchronously to clk.
- Register map (addr):
  - 0 CNAME: RO, 0x48524A44.
  - 1 CVERSION: RO, 0x02000000.
  - 2 TRISTATE: RW.
  - 3 PINSTATE: RO, filtered pin value.
  - 4 INT_MASK: RW.
  - 5 DATAREG: RW.
  - 6 SCRATCH: RW, 32 bits.
  - 7 INT_PENDING: read, write-1-to-clear.
  - 8 INT_RISE: RW, rising-edge enable.
  - 9 INT_FALL: RW, falling-edge enable.
  - 10 DATA_SET: WO, 1 bits set DATAREG, reads 0.
  - 11 DATA_CLR: WO, 1 bits clear DATAREG, reads 0.
  - 12 PARAMS: RO; [5:0] NUM_PINS, [11:8] SYNC_STAGES, [16] debounce present.
  - 13-15: reserved, read 0, writes ignored.
- Write: takes effect on the clk edge where sel=1 and r_wn=0, honouring wben per byte lane.
- Read: sel=1 and r_wn=1 loads rdata on that edge, so data is visible the following cycle (1-cycle latency). rdata holds its value when there is no read.
- Pin path: ro_gpio_pinstate passes through SYNC_STAGES flops to give pin_s. The filtered value pin_f equals pin_s, or the debounce output when that is compiled in.
- Edge history pin_q <= pin_f every cycle.
- Arm counter: counts SYNC_STAGES+1 cycles after reset release, plus DEBOUNCE_CYCLES if debounce is compiled in. No edges are detected until it saturates, which prevents spurious edges at reset.
- Edge detect, per pin i, once armed:
  - rise_i = pin_f[i] & ~pin_q[i] & INT_RISE[i]
  - fall_i = ~pin_f[i] & pin_q[i] & INT_FALL[i]
  - pending[i] sets on rise_i | fall_i.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins, bit stays 1.
- A read of INT_PENDING returns the value before that cycle's update.
- gpio_irq <= |(INT_PENDING & INT_MASK). It rises 1 cycle after pending sets and drops 1 cycle after the clearing write or mask write.
- Pending bits latch even when masked; unmasking a set pending bit raises gpio_irq the next cycle.
- DATA_SET and DATA_CLR writing the same bit cannot happen (single access per cycle). A DATAREG write applies wben-masked data directly.
- Edge detect covers all pins, including pins driven as outputs (TRISTATE=1), because pins read back.
- sel=0 leaves all registers unchanged regardless of r_wn.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- When defined:
  - Per-pin counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
  - pin_f[i] updates to pin_s[i] only after pin_s[i] differs from pin_f[i] for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to equality resets that pin's counter to 0.
  - PARAMS[16]=1.
- When undefined:
  - pin_f = pin_s, no counters are instantiated, PARAMS[16]=0.
  - The arm counter excludes DEBOUNCE_CYCLES.

Test Plan:
- Reset, then read addr 0, 1, 12 with defaults -> rdata 0x48524A44, 0x02000000, 0x00000210 one cycle after each read strobe; all outputs 0.
- Write DATAREG 0x0000A5A5 with wben=0001, then DATA_SET 0x0F00, then DATA_CLR 0x0005 -> rf_gpio_datareg 0x00A5, then 0x0FA5, then 0x0FA0.
- INT_RISE=0x0001, INT_MASK=0x0001; drive pin0 0->1 -> PINSTATE bit0 =1 after SYNC_STAGES+1 cycles, pending[0]=1 the next cycle, gpio_irq=1 one cycle later. W1C 0x0001 -> gpio_irq=0 one cycle after the write.
- Hold pin0 rising edge and W1C of pending[0] in the same cycle -> pending[0] remains 1, gpio_irq stays 1.
- Hold pin3=1 through reset release with INT_RISE=0xFFFF written immediately -> no pending bits set. Assert reset_n low mid-operation -> all outputs 0 with no clock edge required.
- With GPIO_DEBOUNCE_EN: drive pin1 high for DEBOUNCE_CYCLES-1 cycles, then low -> PINSTATE bit1 never changes. Hold high for DEBOUNCE_CYCLES cycles -> bit1 becomes 1.

Source files
------------

// File: rtl/gpio_ctrl_v2_if.sv
// gpio_ctrl_v2 peripheral bus: access strobe, 4-bit word address,
// byte enables, read/write select, write data and registered read data.
interface gpio_ctrl_v2_if;
  logic        sel;
  logic [5:2]  addr;
  logic [3:0]  wben;
  logic        r_wn;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel, addr, wben, r_wn, wdata,
    input  rdata
  );

  modport slave (
    input  sel, addr, wben, r_wn, wdata,
    output rdata
  );
endinterface

// File: rtl/gpio_ctrl_v2.sv
// gpio_ctrl_v2: memory-mapped GPIO with input sync, edge irqs, set/clr.
// Ports: clk, reset_n (async low), bus (slave), ro_gpio_pinstate in,
// rf_gpio_datareg/rf_gpio_tristate out, gpio_irq out (registered).
// Optional debounce filter when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl_v2 #(
  parameter int NUM_PINS        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  gpio_ctrl_v2_if.slave       bus,
  input  logic [NUM_PINS-1:0] ro_gpio_pinstate,
  output logic [NUM_PINS-1:0] rf_gpio_datareg,
  output logic [NUM_PINS-1:0] rf_gpio_tristate,
  output logic                gpio_irq
);

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
  logic [NUM_PINS-1:0] pin_s, pin_f;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = ro_gpio_pinstate;
    for (int k = 1; k < SYNC_STAGES; k++)
      sync_d[k] = sync_q[k-1];
  end

  assign pin_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int  CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit  DEB     = 1'b1;
  localparam int  ARM_MAX = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;

  logic [NUM_PINS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_PINS-1:0]         pin_f_q, pin_f_d;

  // counter holds the number of consecutive disagreeing samples so far
  always_comb begin
    cnt_d   = cnt_q;
    pin_f_d = pin_f_q;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (pin_s[i] == pin_f_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        pin_f_d[i] = pin_s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      pin_f_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pin_f_q <= pin_f_d;
    end
  end

  assign pin_f = pin_f_q;
`else
  localparam bit  DEB     = 1'b0;
  localparam int  ARM_MAX = SYNC_STAGES + 1;

  assign pin_f = pin_s;
`endif

  localparam logic [31:0] PARAMS = {15'd0, DEB, 4'd0,
    4'(SYNC_STAGES), 2'd0, 6'(NUM_PINS)};

  function automatic logic [31:0] ext(input logic [NUM_PINS-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NUM_PINS-1:0] = v;
    return r;
  endfunction

  logic [NUM_PINS-1:0] pin_q, pin_d;
  logic [NUM_PINS-1:0] tri_q, tri_d;
  logic [NUM_PINS-1:0] mask_q, mask_d;
  logic [NUM_PINS-1:0] data_q, data_d;
  logic [NUM_PINS-1:0] pend_q, pend_d;
  logic [NUM_PINS-1:0] rise_q, rise_d;
  logic [NUM_PINS-1:0] fall_q, fall_d;
  logic [31:0]         scr_q, scr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;
  logic [8:0]          arm_q, arm_d;

  logic                armed, wr, rd;
  logic [31:0]         bmask, wbits, rmux;
  logic [NUM_PINS-1:0] wp, edges;

  assign armed = (arm_q == 9'(ARM_MAX));
  assign wr    = bus.sel & ~bus.r_wn;
  assign rd    = bus.sel &  bus.r_wn;
  assign bmask = {{8{bus.wben[3]}}, {8{bus.wben[2]}},
                  {8{bus.wben[1]}}, {8{bus.wben[0]}}};
  assign wbits = bus.wdata & bmask;
  assign wp    = NUM_PINS'(wbits);

  // inputs held across reset must not look like edges until armed
  assign edges = armed ?
    ((pin_f & ~pin_q & rise_q) | (~pin_f & pin_q & fall_q)) : '0;

  always_comb begin
    rmux = '0;
    unique case (bus.addr)
      4'd0:    rmux = 32'h4852_4A44;
      4'd1:    rmux = 32'h0200_0000;
      4'd2:    rmux = ext(tri_q);
      4'd3:    rmux = ext(pin_f);
      4'd4:    rmux = ext(mask_q);
      4'd5:    rmux = ext(data_q);
      4'd6:    rmux = scr_q;
      4'd7:    rmux = ext(pend_q);
      4'd8:    rmux = ext(rise_q);
      4'd9:    rmux = ext(fall_q);
      4'd12:   rmux = PARAMS;
      default: rmux = '0;
    endcase
  end

  always_comb begin
    pin_d   = pin_f;
    arm_d   = armed ? arm_q : arm_q + 9'd1;
    tri_d   = tri_q;
    mask_d  = mask_q;
    data_d  = data_q;
    scr_d   = scr_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    pend_d  = pend_q;
    irq_d   = |(pend_q & mask_q);
    rdata_d = rd ? rmux : rdata_q;
    if (wr) begin
      unique case (bus.addr)
        4'd2:  tri_d  = (tri_q  & ~NUM_PINS'(bmask)) | wp;
        4'd4:  mask_d = (mask_q & ~NUM_PINS'(bmask)) | wp;
        4'd5:  data_d = (data_q & ~NUM_PINS'(bmask)) | wp;
        4'd6:  scr_d  = (scr_q  & ~bmask) | wbits;
        4'd7:  pend_d = pend_q & ~wp;
        4'd8:  rise_d = (rise_q & ~NUM_PINS'(bmask)) | wp;
        4'd9:  fall_d = (fall_q & ~NUM_PINS'(bmask)) | wp;
        4'd10: data_d = data_q | wp;
        4'd11: data_d = data_q & ~wp;
        default: ;
      endcase
    end
    // a new edge beats a same-cycle clear
    pend_d = pend_d | edges;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      pin_q   <= '0;
      arm_q   <= '0;
      tri_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      scr_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      sync_q  <= sync_d;
      pin_q   <= pin_d;
      arm_q   <= arm_d;
      tri_q   <= tri_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      scr_q   <= scr_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata        = rdata_q;
  assign rf_gpio_datareg  = data_q;
  assign rf_gpio_tristate = tri_q;
  assign gpio_irq         = irq_q;

endmodule

// File: tb/tb_gpio_ctrl_v2.sv
// Directed bench for gpio_ctrl_v2: register map, set/clr, edge irqs,
// reset behaviour and (when compiled in) the debounce filter.
module tb_gpio_ctrl_v2;
  localparam int NP  = 16;
  localparam int SS  = 2;
  localparam int DC  = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DLY = DC;
  localparam logic [31:0] PARAMS_EXP = 32'h0001_0210;
`else
  localparam int DLY = 0;
  localparam logic [31:0] PARAMS_EXP = 32'h0000_0210;
`endif
  localparam int LAT = SS + 2 + DLY;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] pins = '0;
  logic [NP-1:0] dreg, tris;
  logic          irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  gpio_ctrl_v2_if bus();

  gpio_ctrl_v2 #(
    .NUM_PINS(NP), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .ro_gpio_pinstate(pins),
    .rf_gpio_datareg(dreg),
    .rf_gpio_tristate(tris),
    .gpio_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be,
                    input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.r_wn = 1'b0;
    bus.addr = a; bus.wben = be; bus.wdata = d;
    @(negedge clk);
    bus.sel = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp,
                    input string tag);
    logic [31:0] e;
    string t;
    @(negedge clk);
    bus.sel = 1'b1; bus.r_wn = 1'b1; bus.addr = a;
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
    @(negedge clk);
    bus.sel = 1'b0;
    e = sb_exp.pop_front();
    t = sb_tag.pop_front();
    chk(t, bus.rdata, e);
  endtask

  task automatic wait_irq(input logic lvl, input string tag);
    int n;
    n = 0;
    while (irq !== lvl && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n), 32'(LAT));
  endtask

  initial begin
    bus.sel = 1'b0; bus.r_wn = 1'b0; bus.addr = '0;
    bus.wben = '0; bus.wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_datareg", 32'(dreg), 32'h0);
    chk("rst_tristate", 32'(tris), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    reset_n = 1'b1;

    rd(4'd0, 32'h4852_4A44, "rd_cname");
    rd(4'd1, 32'h0200_0000, "rd_cversion");
    rd(4'd12, PARAMS_EXP, "rd_params");
    @(negedge clk);
    chk("rdata_hold", bus.rdata, PARAMS_EXP);

    wr(4'd5, 4'b0001, 32'h0000_A5A5);
    chk("datareg_wben", 32'(dreg), 32'h00A5);
    wr(4'd10, 4'b1111, 32'h0000_0F00);
    chk("data_set", 32'(dreg), 32'h0FA5);
    wr(4'd11, 4'b1111, 32'h0000_0005);
    chk("data_clr", 32'(dreg), 32'h0FA0);
    rd(4'd10, 32'h0, "rd_data_set_zero");

    wr(4'd2, 4'b1111, 32'hFFFF_FFFF);
    chk("tristate_out", 32'(tris), 32'h0000_FFFF);
    rd(4'd2, 32'h0000_FFFF, "tristate_upper_zero");

    wr(4'd6, 4'b1111, 32'hDEAD_BEEF);
    wr(4'd6, 4'b0100, 32'h0011_2233);
    rd(4'd6, 32'hDE11_BEEF, "scratch_bytes");
    @(negedge clk);
    bus.sel = 1'b0; bus.r_wn = 1'b0; bus.addr = 4'd6;
    bus.wben = 4'hF; bus.wdata = 32'h1234_5678;
    @(negedge clk);
    rd(4'd6, 32'hDE11_BEEF, "sel_low_no_write");
    wr(4'd13, 4'b1111, 32'hFFFF_FFFF);
    rd(4'd13, 32'h0, "reserved_zero");

    wr(4'd8, 4'b1111, 32'h1);
    wr(4'd4, 4'b1111, 32'h1);
    pins[0] = 1'b1;
    wait_irq(1'b1, "rise_irq_latency");
    rd(4'd3, 32'h1, "pinstate_bit0");
    rd(4'd7, 32'h1, "pending_rise");
    wr(4'd7, 4'b1111, 32'h1);
    chk("irq_after_w1c_edge", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);

    wr(4'd9, 4'b1111, 32'h1);
    pins[0] = 1'b0;
    wait_irq(1'b1, "fall_irq_latency");
    rd(4'd7, 32'h1, "pending_fall");
    wr(4'd9, 4'b1111, 32'h0);

    wr(4'd4, 4'b1111, 32'h0);
    @(negedge clk);
    chk("irq_masked", 32'(irq), 32'h0);
    wr(4'd4, 4'b1111, 32'h1);
    chk("irq_unmask_lag", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_unmasked", 32'(irq), 32'h1);

    pins[0] = 1'b1;
    repeat (SS + DLY - 1) @(negedge clk);
    wr(4'd7, 4'b1111, 32'h1);
    @(negedge clk);
    chk("set_wins_irq", 32'(irq), 32'h1);
    rd(4'd7, 32'h1, "set_wins_pending");

    pins[3] = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_datareg", 32'(dreg), 32'h0);
    chk("async_rst_tristate", 32'(tris), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_rdata", bus.rdata, 32'h0);
    repeat (2) @(negedge clk);
    pins[0] = 1'b0;
    reset_n = 1'b1;
    wr(4'd8, 4'b1111, 32'h0000_FFFF);
    repeat (10 + DLY) @(negedge clk);
    rd(4'd7, 32'h0, "no_spurious_pending");
    rd(4'd3, 32'h8, "pinstate_pin3");

`ifdef GPIO_DEBOUNCE_EN
    pins[1] = 1'b1;
    repeat (DC - 1) @(negedge clk);
    pins[1] = 1'b0;
    repeat (DC + 6) @(negedge clk);
    rd(4'd3, 32'h8, "debounce_short_pulse");
    pins[1] = 1'b1;
    repeat (DC) @(negedge clk);
    pins[1] = 1'b0;
    repeat (4) @(negedge clk);
    rd(4'd3, 32'hA, "debounce_full_pulse");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
